encoder_4to2: RTL and testbench
===============================

ENCODER_4TO2 -- requirements
Module: encoder_4to2

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 enc_in_0..enc_in_3  input  1 each  one-hot request lines, same meaning as decoder outputs dec_out_0..3.
REQ-005 in_valid  input  1  enc_in_* lines qualified this cycle.
REQ-006 in_ready  output  1  block accepts an input this cycle.
REQ-007 enc_out  output  2  encoded index of the head FIFO entry.
REQ-008 out_valid  output  1  enc_out holds a valid entry.
REQ-009 out_ready  input  1  downstream consumes the entry this cycle.
REQ-010 err  output  1  one-cycle pulse: accepted input was not one-hot.
REQ-011 err_cnt  output  8  count of accepted non-one-hot inputs, saturating at 255.
REQ-012 Parameter DEPTH, default 2, output FIFO depth (power of two, >= 2).

Function
REQ-013 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-014 in_ready SHALL equal (FIFO not full) OR out_ready in the same cycle (push on full allowed when a pop coincides).
REQ-015 Accepted exactly-one-hot input SHALL push its index (enc_in_k -> k) into the FIFO.
REQ-016 Accepted input with two or more lines high SHALL push the highest asserted index and assert err for the next cycle.
REQ-017 Accepted input with all lines low SHALL push nothing and assert err for the next cycle.
REQ-018 Latency: accepted input on cycle N into empty FIFO SHALL present out_valid=1 and enc_out on cycle N+1.
REQ-019 enc_out and out_valid SHALL come from registers only; no combinational path from enc_in_* or in_valid to enc_out/out_valid.
REQ-020 enc_out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-021 FIFO order SHALL be preserved; pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-022 Simultaneous push and pop at any occupancy (including full and empty-with-registered-head) SHALL leave occupancy unchanged and lose no entry.
REQ-023 Pop when empty SHALL be impossible (out_valid=0); out_ready while empty SHALL have no effect.
REQ-024 in_valid while in_ready=0 SHALL have no effect; no err, no count.
REQ-025 err_cnt SHALL increment by 1 per err event and hold at 255.
REQ-026 Control FSM states: EMPTY (out_valid=0), ACTIVE (1..DEPTH-1 entries), FULL (DEPTH entries); transitions only on push/pop per REQ-013.

Reset
REQ-027 While rst_n=0 at a clk edge: FIFO emptied, state EMPTY, out_valid=0, enc_out=2'b00, err=0, err_cnt=0.
REQ-028 in_ready SHALL be 0 during reset cycles and 1 from the first cycle after rst_n returns high.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; no entry presented after reset release without a new push.

Structure
REQ-030 Shared package SHALL hold the FSM state type (EMPTY/ACTIVE/FULL), ENC_W=2, ERR_CNT_W=8, ERR_CNT_MAX=255.
REQ-031 FIFO storage and pointers SHALL be one sub-module, enc_fifo, parameterised by DEPTH and data width ENC_W; encode logic, err logic and FSM stay in encoder_4to2.

Verification
REQ-032 After reset, drive enc_in=0001,0010,0100,1000 back-to-back with out_ready=1 -> enc_out 0,1,2,3 on consecutive cycles starting one cycle after first accept, err never set.
REQ-033 out_ready=0, push 3 valid inputs (DEPTH=2) -> first two accepted, in_ready=0 on third, then out_ready=1 -> outputs in order, third accepted on pop cycle.
REQ-034 Full FIFO, in_valid=1 and out_ready=1 same cycle -> occupancy stays 2, both head pop and new push observed, no loss.
REQ-035 enc_in=0110 accepted -> enc_out=2, err pulse 1 cycle, err_cnt=1; enc_in=0000 accepted -> no push, err pulse, err_cnt=2.
REQ-036 300 consecutive accepted 0000 inputs -> err_cnt=255 and held.
REQ-037 Fill FIFO, assert rst_n=0 one cycle with out_ready=0 -> out_valid=0, err_cnt=0, in_ready=0 during reset, 1 afterwards.

Source files
------------

// File: rtl/encoder_4to2_pkg.sv
// rtl/encoder_4to2_pkg.sv - shared types, widths and encode helpers for encoder_4to2
package encoder_4to2_pkg;

    localparam int ENC_W       = 2;
    localparam int ERR_CNT_W   = 8;
    localparam int ERR_CNT_MAX = 255;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } enc_state_t;

    // Priority encode: the highest asserted line wins when several are high.
    function automatic logic [ENC_W-1:0] highest_index(input logic [3:0] lines);
        logic [ENC_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (lines[k]) begin
                idx = ENC_W'(k);
            end
        end
        return idx;
    endfunction

    function automatic logic is_one_hot(input logic [3:0] lines);
        return (lines != 4'b0000) && ((lines & (lines - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/encoder_4to2_enc_fifo.sv
// rtl/encoder_4to2_enc_fifo.sv - encoded-index FIFO storage, pointers and occupancy
module enc_fifo
    import encoder_4to2_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/encoder_4to2.sv
// rtl/encoder_4to2.sv - 4-to-2 request encoder with error counting and output FIFO
module encoder_4to2
    import encoder_4to2_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enc_in_0,
    input  logic                 enc_in_1,
    input  logic                 enc_in_2,
    input  logic                 enc_in_3,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ENC_W-1:0]     enc_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    enc_state_t       state;
    logic [3:0]       lines;
    logic             accept;
    logic             push;
    logic             pop;
    logic             bad;
    logic             full;
    logic [CW-1:0]    count;
    logic [ENC_W-1:0] head;

    assign lines  = {enc_in_3, enc_in_2, enc_in_1, enc_in_0};
    assign full   = (state == FULL);

    // Gating with rst_n keeps the input side closed during reset cycles.
    assign in_ready = rst_n && (!full || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign push     = accept && (lines != 4'b0000);
    assign bad      = accept && !is_one_hot(lines);

    enc_fifo #(
        .DEPTH (DEPTH),
        .W     (ENC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (highest_index(lines)),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (push && !pop && count == CW'(DEPTH - 1)) begin
                        state <= FULL;
                    end else if (pop && !push && count == CW'(1)) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop && !push) begin
                        state <= ACTIVE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state != EMPTY);
    assign enc_out   = head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= bad;
            if (bad && err_cnt != ERR_CNT_W'(ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_encoder_4to2.sv
// tb/tb_encoder_4to2.sv - self-checking bench for encoder_4to2 against a queue model
module tb_encoder_4to2;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic       in_valid;
    logic       out_ready;
    logic       in_ready;
    logic [1:0] enc_out;
    logic       out_valid;
    logic       err;
    logic [7:0] err_cnt;

    int q[$];
    int exp_err;
    int exp_cnt;
    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    encoder_4to2 #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_in_0  (din[0]),
        .enc_in_1  (din[1]),
        .enc_in_2  (din[2]),
        .enc_in_3  (din[3]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc_out   (enc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int top_line(input logic [3:0] d);
        int r;
        r = -1;
        for (int k = 0; k < 4; k++) begin
            if (d[k]) r = k;
        end
        return r;
    endfunction

    // One clock cycle: drive, check pre-edge outputs against the model, then advance the model.
    task automatic step(input logic [3:0] d, input logic v, input logic r);
        int  exp_rdy;
        bit  acc;
        bit  pop;
        din = d;
        in_valid = v;
        out_ready = r;
        #3;
        exp_rdy = (rst_n && (q.size() < DEPTH || r)) ? 1 : 0;
        check("in_ready", int'(in_ready), exp_rdy);
        check("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) check("enc_out", int'(enc_out), q[0]);
        check("err", int'(err), exp_err);
        check("err_cnt", int'(err_cnt), exp_cnt);
        acc = v && (exp_rdy == 1);
        pop = r && (q.size() != 0);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            exp_err = 0;
            exp_cnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && $countones(d) > 0) q.push_back(top_line(d));
            exp_err = (acc && $countones(d) != 1) ? 1 : 0;
            if (exp_err == 1 && exp_cnt < 255) exp_cnt++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        exp_err = 0;
        exp_cnt = 0;
        rst_n = 1'b0;
        din = 4'b0000;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        step(4'b0000, 1'b1, 1'b1);
        check("enc_out_rst", int'(enc_out), 0);
        rst_n = 1'b1;

        // back-to-back one-hot stream
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b1);
        step(4'b0100, 1'b1, 1'b1);
        step(4'b1000, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // backpressure: third push stalls until a pop coincides
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        check("full_in_ready", int'(in_ready), 0);
        step(4'b1000, 1'b1, 1'b1);
        step(4'b0010, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // multi-hot and all-zero inputs
        step(4'b0110, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("multi_hot_head", int'(enc_out), 2);
        step(4'b0000, 1'b0, 1'b1);
        check("err_cnt_two", int'(err_cnt), 2);
        step(4'b0000, 1'b0, 1'b0);

        // saturation of the error counter
        for (int i = 0; i < 300; i++) step(4'b0000, 1'b1, 1'b1);
        check("err_cnt_sat", int'(err_cnt), 255);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        // reset while full discards stored entries
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        rst_n = 1'b0;
        step(4'b0100, 1'b1, 1'b0);
        rst_n = 1'b1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // randomized traffic with rare resets
        for (int i = 0; i < 600; i++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) d = 4'(1 << $urandom_range(0, 3));
            rst_n = ($urandom_range(0, 99) != 0);
            step(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rst_n = 1'b1;
        step(4'b0000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
